// File: rtl/timer_sched_pkg.sv
// Shared types and sizing helpers for the timer scheduler.
// The FSM state encoding and the grant-index width rule live here so the top and the arbiter agree.
package timer_sched_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_CNTR_WIDTH = 4;

   // Keep the index at least one bit wide, even for degenerate requester counts.
   function automatic int idw_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/timer_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or above the pointer, wrapping at NUM_REQ.
// The pointer moves past the winner only when the grant is actually taken (i_adv).
module rr_arbiter
   import timer_sched_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDW     = idw_of(NUM_REQ)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_en,
   input  logic               i_adv,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDW-1:0]     o_idx
);

   logic [IDW-1:0] r_ptr;
   logic [IDW:0]   w_scan;
   logic [IDW-1:0] w_sel;
   logic           w_found;

   // The scan index is one bit wider so the wrap compare never overflows.
   always_comb begin
      w_scan  = '0;
      w_sel   = '0;
      w_found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_scan = {1'b0, r_ptr} + (IDW+1)'(k);
         if (w_scan >= (IDW+1)'(NUM_REQ)) begin
            w_scan = w_scan - (IDW+1)'(NUM_REQ);
         end
         if (!w_found && i_req[w_scan[IDW-1:0]]) begin
            w_found = 1'b1;
            w_sel   = w_scan[IDW-1:0];
         end
      end
   end

   assign o_grant = (i_en && w_found) ? (NUM_REQ'(1) << w_sel) : '0;
   assign o_idx   = w_sel;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr <= '0;
      end else if (i_adv) begin
         r_ptr <= (w_sel == IDW'(NUM_REQ - 1)) ? '0 : w_sel + IDW'(1);
      end
   end

endmodule

// File: rtl/timer_sched.sv
// Shares one interval counter between NUM_REQ requesters; one job at a time, round-robin granted.
//   state | meaning
//   IDLE  | no job; arbiter may accept one request this cycle
//   COUNT | job running, counter climbing toward the latched terminal count
module timer_sched
   import timer_sched_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int CNTR_WIDTH = DEF_CNTR_WIDTH,
   parameter int IDW        = idw_of(NUM_REQ)
) (
   input  logic                                i_clk,
   input  logic                                i_rst,
   input  logic [NUM_REQ-1:0]                  i_req_valid,
   input  logic [NUM_REQ-1:0][CNTR_WIDTH-1:0]  i_req_len,
   output logic [NUM_REQ-1:0]                  o_req_ready,
   input  logic                                i_abort,
   output logic [NUM_REQ-1:0]                  o_done,
   output logic                                o_busy,
   output logic [IDW-1:0]                      o_grant_id,
   output logic [CNTR_WIDTH-1:0]               o_cntr
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CNTR_WIDTH-1:0] r_cntr;
   logic [CNTR_WIDTH-1:0] r_len_q;
   logic [IDW-1:0]        r_grant_id;
   logic [NUM_REQ-1:0]    w_grant;
   logic [IDW-1:0]        w_arb_idx;
   logic                  w_arb_en;
   logic                  w_accept;
   logic                  w_at_len;
   logic                  w_done_fire;

   assign w_arb_en = (r_state == IDLE) && !i_rst;
   assign w_accept = |w_grant;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_arb (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_req   (i_req_valid),
      .i_en    (w_arb_en),
      .i_adv   (w_accept),
      .o_grant (w_grant),
      .o_idx   (w_arb_idx)
   );

   assign w_at_len    = (r_cntr == r_len_q);
   // Abort beats a coincident terminal count; reset suppresses everything.
   assign w_done_fire = (r_state == COUNT) && w_at_len && !i_abort && !i_rst;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:  if (w_accept)             w_state_nxt = COUNT;
         COUNT: if (i_abort || w_at_len)  w_state_nxt = IDLE;
         default:                         w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_cntr     <= '0;
         r_len_q    <= '0;
         r_grant_id <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_len_q    <= i_req_len[w_arb_idx];
            r_grant_id <= w_arb_idx;
            r_cntr     <= '0;
         end else if (r_state == COUNT && !i_abort && !w_at_len) begin
            r_cntr <= r_cntr + CNTR_WIDTH'(1);
         end
      end
   end

   assign o_req_ready = w_grant;
   assign o_done      = w_done_fire ? (NUM_REQ'(1) << r_grant_id) : '0;
   assign o_busy      = (r_state == COUNT);
   assign o_grant_id  = r_grant_id;
   assign o_cntr      = r_cntr;

endmodule
